// File: rtl/arb_pkg.sv
// Shared types, constants and the 4:2 grant encoder for the round-robin arbiter.
package arb_pkg;

  localparam int NREQ_C = 4;
  localparam int IDXW_C = 2;

  typedef logic [3:0] req_vec_t;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // One-hot to binary encode; a non-one-hot input maps to 0 so the mux select stays defined.
  function automatic logic [1:0] onehot2idx(input req_vec_t oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4_enc_chk.sv
// Invariant checker for rr_arb4_enc: grant shape, index consistency and request causality.
module rr_arb4_enc_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [3:0] req,
  input logic [3:0] gnt,
  input logic [1:0] gnt_idx,
  input logic       gnt_valid
);

  a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_valid : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));

  a_idx : assert property (@(posedge clk) disable iff (!rst_n)
                           gnt_valid |-> (gnt == (4'b0001 << gnt_idx)));

  a_cause : assert property (@(posedge clk) disable iff (!rst_n)
                             (gnt & ~$past(req)) == 4'b0000);

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: first requester at or after i_ptr (mod 4),
// ignoring anything in the exclude mask.
module rr_pick4
  import arb_pkg::*;
(
  input  req_vec_t   i_req_vec,
  input  logic [1:0] i_ptr,
  input  req_vec_t   i_excl,
  output req_vec_t   o_win,
  output logic       o_found
);

  req_vec_t   w_masked;
  logic [1:0] w_pos;

  assign w_masked = i_req_vec & ~i_excl;

  // Walk the four positions starting at the pointer and take the first live request.
  always_comb begin
    o_win   = 4'b0000;
    o_found = 1'b0;
    w_pos   = 2'd0;
    for (int d = 0; d < 4; d++) begin
      w_pos = i_ptr + 2'(d);
      if (!o_found && w_masked[w_pos]) begin
        o_win[w_pos] = 1'b1;
        o_found      = 1'b1;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with locked grants, an encoded grant index
// for the downstream 4:2 mux, and an optional hold limit that forces rotation.
module rr_arb4_enc
  import arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDXW     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            preempt
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit so 0/1 still elaborate.
  localparam int HOLDW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLDW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLDW'(MAX_HOLD - 1) : {HOLDW{1'b0}};

  arb_state_t       r_state;
  req_vec_t         r_gnt;
  logic [1:0]       r_idx;
  logic             r_valid;
  logic             r_preempt;
  logic [1:0]       r_ptr;
  logic [HOLDW-1:0] r_hold;

  arb_state_t       w_state_n;
  req_vec_t         w_gnt_n;
  logic [1:0]       w_idx_n;
  logic             w_valid_n;
  logic             w_preempt_n;
  logic [1:0]       w_ptr_n;
  logic [HOLDW-1:0] w_hold_n;

  req_vec_t         w_req;
  req_vec_t         w_others;
  req_vec_t         w_excl;
  req_vec_t         w_win;
  logic             w_found;
  logic             w_owner_req;
  logic             w_expire;

  assign w_req       = req;
  assign w_others    = w_req & ~r_gnt;
  assign w_owner_req = w_req[r_idx];

  // Expiry only matters while the owner still wants the bus and someone else is waiting;
  // an owner release on the same edge takes the plain release path instead.
  assign w_expire = (MAX_HOLD != 0) && (r_state == ARB_GRANT) && w_owner_req &&
                    (r_hold == HOLD_LAST) && (w_others != 4'b0000);

  // On expiry the current owner is masked so the search lands on someone else.
  assign w_excl = w_expire ? r_gnt : 4'b0000;

  // The pointer already sits one past the owner, so one picker serves idle, release and expiry.
  rr_pick4 u_pick (
    .i_req_vec (w_req),
    .i_ptr     (r_ptr),
    .i_excl    (w_excl),
    .o_win     (w_win),
    .o_found   (w_found)
  );

  // Next-state decision for the two-state grant machine.
  always_comb begin
    w_state_n   = r_state;
    w_gnt_n     = r_gnt;
    w_idx_n     = r_idx;
    w_valid_n   = r_valid;
    w_preempt_n = 1'b0;
    w_ptr_n     = r_ptr;
    w_hold_n    = r_hold;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_state_n = ARB_GRANT;
          w_gnt_n   = w_win;
          w_idx_n   = onehot2idx(w_win);
          w_valid_n = 1'b1;
          w_ptr_n   = onehot2idx(w_win) + 2'd1;
          w_hold_n  = {HOLDW{1'b0}};
        end else begin
          w_state_n = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        if (!w_owner_req || w_expire) begin
          if (w_found) begin
            w_gnt_n     = w_win;
            w_idx_n     = onehot2idx(w_win);
            w_valid_n   = 1'b1;
            w_ptr_n     = onehot2idx(w_win) + 2'd1;
            w_hold_n    = {HOLDW{1'b0}};
            w_preempt_n = w_expire;
          end else begin
            w_state_n = ARB_IDLE;
            w_gnt_n   = 4'b0000;
            w_idx_n   = 2'd0;
            w_valid_n = 1'b0;
            w_hold_n  = {HOLDW{1'b0}};
          end
        end else if (r_hold != HOLD_LAST) begin
          w_hold_n = r_hold + {{(HOLDW-1){1'b0}}, 1'b1};
        end else begin
          w_hold_n = r_hold;
        end
      end
      default: begin
        w_state_n = ARB_IDLE;
        w_gnt_n   = 4'b0000;
        w_idx_n   = 2'd0;
        w_valid_n = 1'b0;
        w_hold_n  = {HOLDW{1'b0}};
      end
    endcase
  end

  // State, pointer, hold counter and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= 4'b0000;
      r_idx     <= 2'd0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
      r_ptr     <= 2'd0;
      r_hold    <= {HOLDW{1'b0}};
    end else begin
      r_state   <= w_state_n;
      r_gnt     <= w_gnt_n;
      r_idx     <= w_idx_n;
      r_valid   <= w_valid_n;
      r_preempt <= w_preempt_n;
      r_ptr     <= w_ptr_n;
      r_hold    <= w_hold_n;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arb4_enc.sv
module tb_rr_arb4_enc;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt0, gnt8, gnt4;
  logic [1:0] idx0, idx8, idx4;
  logic       val0, val8, val4;
  logic       pre0, pre8, pre4;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  rr_arb4_enc #(.NREQ(4), .IDXW(2), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .preempt(pre0));
  rr_arb4_enc #(.NREQ(4), .IDXW(2), .MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8), .preempt(pre8));
  rr_arb4_enc #(.NREQ(4), .IDXW(2), .MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4), .preempt(pre4));

  rr_arb4_enc_chk chk0 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0));
  rr_arb4_enc_chk chk8 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(val8));
  rr_arb4_enc_chk chk4 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(val4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: owner (-1 when idle), rotation pointer, cycles owned so far.
  typedef struct {
    int owner;
    int ptr;
    int run;
    bit pre;
  } mstate_t;

  mstate_t m0, m8, m4;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int d = 0; d < 4; d++) begin
      if (r[(start + d) % 4]) return (start + d) % 4;
    end
    return -1;
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.owner = -1; s.ptr = 0; s.run = 0; s.pre = 1'b0;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input logic [3:0] r, input int mh);
    mstate_t n;
    logic [3:0] others;
    int k;
    n = s;
    n.pre = 1'b0;
    if (s.owner < 0) begin
      k = first_from(r, s.ptr);
      if (k >= 0) begin n.owner = k; n.ptr = (k + 1) % 4; n.run = 1; end
    end else if (!r[s.owner]) begin
      k = first_from(r, (s.owner + 1) % 4);
      if (k >= 0) begin n.owner = k; n.ptr = (k + 1) % 4; n.run = 1; end
      else begin n.owner = -1; n.run = 0; end
    end else begin
      others = r;
      others[s.owner] = 1'b0;
      if (mh != 0 && s.run >= mh && others != 4'b0000) begin
        k = first_from(others, (s.owner + 1) % 4);
        n.owner = k; n.ptr = (k + 1) % 4; n.run = 1; n.pre = 1'b1;
      end else if (s.run < 100000) begin
        n.run = s.run + 1;
      end
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUTs and resets asynchronously with them.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset(); m8 <= mreset(); m4 <= mreset();
    end else begin
      m0 <= mstep(m0, req, 0);
      m8 <= mstep(m8, req, 8);
      m4 <= mstep(m4, req, 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic [3:0] g, input logic [1:0] ix,
                          input logic v, input logic p, input mstate_t m);
    logic [3:0] eg;
    logic [1:0] ei;
    eg = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
    ei = (m.owner < 0) ? 2'd0 : 2'(m.owner);
    chk({tag, ".gnt"}, {28'd0, g}, {28'd0, eg});
    chk({tag, ".idx"}, {30'd0, ix}, {30'd0, ei});
    chk({tag, ".valid"}, {31'd0, v}, {31'd0, (m.owner >= 0)});
    chk({tag, ".preempt"}, {31'd0, p}, {31'd0, m.pre});
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      cmp_inst("mh0", gnt0, idx0, val0, pre0, m0);
      cmp_inst("mh8", gnt8, idx8, val8, pre8, m8);
      cmp_inst("mh4", gnt4, idx4, val4, pre4, m4);
    end
  end

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  logic [3:0] fair_req [5];
  int         fair_idx [5];
  int         cnt0;
  logic [3:0] r;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.gnt", {28'd0, gnt8}, 32'd0);
    chk("reset.valid", {31'd0, val8}, 32'd0);
    chk("reset.idx", {30'd0, idx4}, 32'd0);
    chk("reset.preempt", {31'd0, pre0}, 32'd0);
    chk_en = 1'b1;

    // Single requester: grant follows one cycle later and ptr ends at 3.
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0100);
      chk("single.gnt", {28'd0, gnt8}, 32'h4);
      chk("single.idx", {30'd0, idx8}, 32'd2);
    end
    cyc(4'b0000);
    chk("single.drop", {28'd0, gnt8}, 32'h0);
    cyc(4'b1001);
    chk("single.ptr3", {30'd0, idx8}, 32'd3);
    cyc(4'b0000);

    // Fairness with preemption disabled: back-to-back handoffs in rotation order.
    do_reset();
    fair_req[0] = 4'b1111; fair_idx[0] = 0;
    fair_req[1] = 4'b1110; fair_idx[1] = 1;
    fair_req[2] = 4'b1101; fair_idx[2] = 2;
    fair_req[3] = 4'b1011; fair_idx[3] = 3;
    fair_req[4] = 4'b0111; fair_idx[4] = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(fair_req[i]);
      chk("fair.idx", {30'd0, idx0}, fair_idx[i]);
      chk("fair.valid", {31'd0, val0}, 32'd1);
    end
    cyc(4'b0000);

    // Preemption after eight grant cycles.
    do_reset();
    cnt0 = 0;
    cyc(4'b0001); if (gnt8 == 4'b0001) cnt0++;
    cyc(4'b0001); if (gnt8 == 4'b0001) cnt0++;
    for (int i = 0; i < 6; i++) begin
      cyc(4'b0011);
      if (gnt8 == 4'b0001) cnt0++;
      chk("preempt.early", {31'd0, pre8}, 32'd0);
    end
    chk("preempt.hold8", cnt0, 32'd8);
    cyc(4'b0011);
    chk("preempt.gnt", {28'd0, gnt8}, 32'h2);
    chk("preempt.pulse", {31'd0, pre8}, 32'd1);
    cyc(4'b0011);
    chk("preempt.once", {31'd0, pre8}, 32'd0);
    chk("preempt.keep", {28'd0, gnt8}, 32'h2);

    // Lone hog never preempted.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(4'b1000);
      chk("hog.gnt", {28'd0, gnt8}, 32'h8);
      chk("hog.pre", {31'd0, pre8 | pre4}, 32'd0);
    end

    // Reset mid-grant drops the grant without a clock edge.
    do_reset();
    cyc(4'b0010);
    chk("rstmid.pre", {28'd0, gnt8}, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.gnt", {28'd0, gnt8}, 32'h0);
    chk("rstmid.valid", {31'd0, val8}, 32'd0);
    rst_n = 1'b1;
    cyc(4'b0110);
    chk("rstmid.after", {28'd0, gnt8}, 32'h2);

    // Owner releases exactly when expiry would fire: plain release, no preempt.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(4'b0011);
    chk("coll.own", {28'd0, gnt4}, 32'h1);
    cyc(4'b0010);
    chk("coll.gnt", {28'd0, gnt4}, 32'h2);
    chk("coll.pre", {31'd0, pre4}, 32'd0);

    // Randomized traffic with sticky-ish requests, checked every cycle by the model.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) r[b] = ~r[b];
      end
      cyc(r);
    end
    cyc(4'b0000);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb4_enc.md
Name: rr_arb4_enc

Overview:
- Four-requester round-robin arbiter for the shared 4:2 encode path.
- Arbitrates single-bit requests, holds a locked grant per owner, and publishes the grant both one-hot and as a 2-bit encoded index.
- The grant index is the select for the downstream encoder/mux.
- Optional hold-limit forces rotation so no requester starves the others.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 for this revision.
- IDXW, 2, width of the encoded grant index; equals clog2(NREQ).
- MAX_HOLD, 8, maximum consecutive grant cycles per owner while other requests are pending; 0 disables preemption.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  active-high requests; req[i] stays high for as long as requester i wants the resource.
- gnt  output  4  one-hot registered grant; all zeros when idle.
- gnt_idx  output  2  binary index of the granted requester; 0 when idle.
- gnt_valid  output  1  high when any grant is active; equals |gnt.
- preempt  output  1  one-cycle pulse on the cycle a grant is issued because of a MAX_HOLD expiry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
  - ptr=0, hold_cnt=0, state=IDLE.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- All outputs are registered. A request is granted 1 cycle after it is sampled high.
- Winner selection:
  - Priority starts at ptr and wraps: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On every new grant to index k, ptr <= k+1 (mod 4); 3 wraps to 0.
- State machine (2 states):
  - IDLE:
    - req==0: stay in IDLE.
    - Otherwise: grant the winner, go to GRANT, hold_cnt <= 0.
  - GRANT (owner o):
    - req[o]==1 and not expired: keep the grant; hold_cnt increments and saturates at MAX_HOLD-1.
    - req[o]==0 with other requests pending: grant the next winner (search from o+1) at the same edge. This is a back-to-back handoff with no idle gap.
    - req[o]==0 with no other requests: gnt <= 0, go to IDLE.
    - Expiry (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[o]==1, and another req[j!=o] high): grant the next winner excluding o; preempt=1 for that cycle.
    - Expiry with no other requests pending: the owner keeps the grant and hold_cnt stays saturated.
- Simultaneous events:
  - If the owner drops req on the same edge that expiry would occur, this is treated as a normal release (preempt=0).
  - New requests arriving during a grant are only considered at a release or an expiry.
- Invariants (checked by assertions):
  - gnt is zero or one-hot.
  - gnt_idx matches gnt whenever gnt_valid=1.
  - gnt[i] implies req[i] was high on the previous sampled edge.

Decomposition:
- Package arb_pkg holds:
  - NREQ_C=4 and IDXW_C=2.
  - typedef logic [3:0] req_vec_t.
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t.
  - Function onehot2idx (the 4:2 encode).
- One sub-module: rr_pick4, a combinational rotate-priority picker. Inputs are req_vec, ptr and an exclude mask; outputs are a one-hot winner and a found flag. rr_arb4_enc holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Single requester: release rst_n, req=0100 for 5 cycles then 0000.
  - gnt=0100 and gnt_idx=2 from the cycle after req rises.
  - gnt returns to 0000 one cycle after req drops.
  - ptr ends at 3.
- Fairness: req=1111 held, MAX_HOLD=0, each owner drops its req for 1 cycle then reasserts.
  - Grant order is idx 0,1,2,3,0.
  - No idle gaps between grants.
- Preemption: MAX_HOLD=8, req=0001 at cycle 0, req=0011 from cycle 2, requester 0 never drops.
  - gnt=0001 for 8 cycles.
  - Then gnt=0010 with preempt=1 for exactly one cycle.
- Lone hog: req=1000 only, MAX_HOLD=8, held 20 cycles.
  - gnt=1000 throughout and preempt never fires.
- Reset mid-grant: gnt=0010 active, pulse rst_n low between clock edges.
  - gnt=0000 and gnt_valid=0 immediately.
  - After release with req=0110, gnt=0010 (ptr reset to 0, so idx 1 wins before idx 2).
- Release/expiry collision: MAX_HOLD=4, req=0011 with owner 0 dropping exactly at hold_cnt==3.
  - gnt moves to 0010 and preempt=0.
